// File: rtl/program_loader.sv
// Program loader: streams a length-prefixed, checksummed program into
// instruction memory while holding the CPU in reset.
module program_loader #(
  parameter int INSTR_WIDTH = 8,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [INSTR_WIDTH-1:0] in_data,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   cpu_reset,
  output logic                   done,
  output logic                   error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [INSTR_WIDTH:0] DEPTH_W = (INSTR_WIDTH + 1)'(DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN   = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] CHECK = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;
  localparam logic [2:0] ERR   = 3'd5;

  logic [2:0]             state;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [CW-1:0]          remaining;
  logic [INSTR_WIDTH-1:0] sum;
  logic                   accept;
  logic                   len_bad;

  // Readiness comes from state alone so the upstream sees no comb loop.
  assign in_ready = (state == LEN) || (state == LOAD) || (state == CHECK);
  assign accept   = in_valid & in_ready;
  assign mem_we   = (state == LOAD) & in_valid;
  assign mem_addr = addr;
  assign mem_wdata = in_data;

  assign len_bad = (in_data == '0) || ({1'b0, in_data} > DEPTH_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      sum       <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) state <= LEN;
        end
        LEN: begin
          if (accept) begin
            if (len_bad) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              remaining <= in_data[CW-1:0];
              addr      <= '0;
              sum       <= '0;
              state     <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            addr      <= addr + ADDR_WIDTH'(1);
            sum       <= sum + in_data;
            remaining <= remaining - CW'(1);
            if (remaining == CW'(1)) state <= CHECK;
          end
        end
        CHECK: begin
          if (accept) begin
            if (in_data == sum) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
        RUN: begin
          if (start) begin
            state     <= LEN;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
          end
        end
        ERR: begin
          if (start) begin
            state <= LEN;
            error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: per-cycle vector table plus
// hand-built sequences for full-depth load, restart and async reset.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_reset;
  logic       done;
  logic       error;

  program_loader #(.INSTR_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [7:0] tmem [16];
  always @(posedge clk) if (mem_we) tmem[mem_addr] <= mem_wdata;

  typedef struct {
    bit         st;
    bit         vl;
    logic [7:0] d;
    bit         rdy;
    bit         we;
    logic [3:0] a;
    bit         cr;
    bit         dn;
    bit         er;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(bit st, bit vl, logic [7:0] d, bit rdy,
                              bit we, logic [3:0] a, bit cr, bit dn, bit er);
    vec_t v;
    v.st = st; v.vl = vl; v.d = d; v.rdy = rdy; v.we = we;
    v.a = a; v.cr = cr; v.dn = dn; v.er = er;
    return v;
  endfunction

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    start = v.st; in_valid = v.vl; in_data = v.d;
    #2;
    chk({nm, " ctl{rdy,we,cr,dn,er}"},
        16'({in_ready, mem_we, cpu_reset, done, error}),
        16'({v.rdy, v.we, v.cr, v.dn, v.er}));
    if (v.we) begin
      chk({nm, " addr"}, 16'(mem_addr), 16'(v.a));
      chk({nm, " wdata"}, 16'(mem_wdata), 16'(v.d));
    end
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] w;
    reset = 1'b1; start = 0; in_valid = 0; in_data = 0;
    #3;
    chk("reset ctl", 16'({in_ready, mem_we, cpu_reset, done, error}),
        16'(5'b00100));
    @(negedge clk); reset = 1'b0;

    // basic load
    tbl.push_back(mk(1,0,8'h00, 0,0,0, 1,0,0));
    tbl.push_back(mk(0,1,8'h03, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,1,8'h12, 1,1,0, 1,0,0));
    tbl.push_back(mk(0,1,8'h34, 1,1,1, 1,0,0));
    tbl.push_back(mk(0,1,8'h56, 1,1,2, 1,0,0));
    tbl.push_back(mk(0,1,8'h9C, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,8'h00, 0,0,0, 0,1,0));
    // checksum wrap with backpressure, starting from RUN
    tbl.push_back(mk(1,0,8'h00, 0,0,0, 0,1,0));
    tbl.push_back(mk(0,0,8'h00, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,8'h00, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,1,8'h02, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,8'hFF, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,8'hFF, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,1,8'hFF, 1,1,0, 1,0,0));
    tbl.push_back(mk(0,0,8'h02, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,8'h02, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,1,8'h02, 1,1,1, 1,0,0));
    tbl.push_back(mk(0,0,8'h01, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,8'h01, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,1,8'h01, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,8'h00, 0,0,0, 0,1,0));
    tbl.push_back(mk(0,1,8'h55, 0,0,0, 0,1,0));
    // bad checksum
    tbl.push_back(mk(1,0,8'h00, 0,0,0, 0,1,0));
    tbl.push_back(mk(0,1,8'h01, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,1,8'hA5, 1,1,0, 1,0,0));
    tbl.push_back(mk(0,1,8'hA4, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,1,8'h00, 0,0,0, 1,0,1));
    tbl.push_back(mk(1,0,8'h00, 0,0,0, 1,0,1));
    tbl.push_back(mk(0,0,8'h00, 1,0,0, 1,0,0));
    // bad lengths 0x00 and 0x11
    tbl.push_back(mk(0,1,8'h00, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,8'h00, 0,0,0, 1,0,1));
    tbl.push_back(mk(1,0,8'h00, 0,0,0, 1,0,1));
    tbl.push_back(mk(0,1,8'h11, 1,0,0, 1,0,0));
    tbl.push_back(mk(0,0,8'h00, 0,0,0, 1,0,1));
    tbl.push_back(mk(1,0,8'h00, 0,0,0, 1,0,1));
    tbl.push_back(mk(0,0,8'h00, 1,0,0, 1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
      if (i == 6) begin
        chk("mem0", 16'(tmem[0]), 16'h12);
        chk("mem1", 16'(tmem[1]), 16'h34);
        chk("mem2", 16'(tmem[2]), 16'h56);
      end
    end

    // full-depth load: state is LEN here
    apply(mk(0,1,8'h10, 1,0,0, 1,0,0), "len16");
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      w = 8'(i * 37 + 11);
      s = s + w;
      apply(mk(0,1,w, 1,1,4'(i), 1,0,0), $sformatf("w16_%0d", i));
    end
    apply(mk(0,1,s, 1,0,0, 1,0,0), "sum16");
    apply(mk(0,0,8'h00, 0,0,0, 0,1,0), "run16");
    chk("mem15", 16'(tmem[15]), 16'(w));

    // start during LOAD is ignored
    apply(mk(1,0,8'h00, 0,0,0, 0,1,0), "reload");
    apply(mk(0,0,8'h00, 1,0,0, 1,0,0), "reload_len");
    apply(mk(0,1,8'h02, 1,0,0, 1,0,0), "ign_len");
    apply(mk(1,1,8'h40, 1,1,0, 1,0,0), "ign_w0");
    apply(mk(1,1,8'h41, 1,1,1, 1,0,0), "ign_w1");
    apply(mk(0,1,8'h81, 1,0,0, 1,0,0), "ign_sum");
    apply(mk(0,0,8'h00, 0,0,0, 0,1,0), "ign_run");

    // async reset mid-load
    apply(mk(1,0,8'h00, 0,0,0, 0,1,0), "rst_start");
    apply(mk(0,1,8'h04, 1,0,0, 1,0,0), "rst_len");
    apply(mk(0,1,8'h21, 1,1,0, 1,0,0), "rst_w0");
    apply(mk(0,1,8'h22, 1,1,1, 1,0,0), "rst_w1");
    @(posedge clk); #2;
    chk("pre_rst rdy", 16'(in_ready), 16'h1);
    reset = 1'b1; #1;
    chk("async rst ctl", 16'({in_ready, mem_we, cpu_reset, done, error}),
        16'(5'b00100));
    @(negedge clk); reset = 1'b0; in_valid = 0;
    apply(mk(0,0,8'h00, 0,0,0, 1,0,0), "post_rst_idle");
    apply(mk(1,0,8'h00, 0,0,0, 1,0,0), "post_start");
    apply(mk(0,1,8'h01, 1,0,0, 1,0,0), "post_len");
    apply(mk(0,1,8'h5A, 1,1,0, 1,0,0), "post_w0");
    apply(mk(0,1,8'h5A, 1,0,0, 1,0,0), "post_sum");
    apply(mk(0,0,8'h00, 0,0,0, 0,1,0), "post_run");
    start = 0; in_valid = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
